// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Main control FSM for a multicycle MIPS datapath. Sequences fetch, decode, execute, memory
//   and writeback steps and drives the datapath mux selects and write enables. Memory-facing
//   states (FETCH, MEMRD, MEMWR) hold until mem_ready.
//
// Parameters
//   IMM_LOGIC_EN  1: andi/ori are decoded (zero-extended immediate); 0: they are illegal
//
// Ports
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   opcode        instr[31:26] from IR, only looked at in DECODE
//   mem_ready     memory access completes this cycle
//   pc_write, branch, pc_src            PC update control
//   i_or_d, mem_write, ir_write         memory / IR control
//   reg_dst, mem_to_reg, reg_write      register-file control
//   alu_src_a, alu_src_b, alu_op        ALU operand and operation selects
//   ext_sel       1 sign-extend, 0 zero-extend the 16-bit immediate
//   illegal_op    pulse in DECODE for an unsupported opcode
//   state_o       current state encoding, for debug

module mips_multicycle_ctrl #(
    parameter bit IMM_LOGIC_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       ext_sel,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StImmEx  = 4'd9,
        StImmWb  = 4'd10,
        StJump   = 4'd11
    } state_t;

    state_t     state;
    logic [5:0] op_q;
    state_t     dec_next;
    logic       dec_legal;

    // Opcode decode for the DECODE state; looks at the live opcode, not op_q.
    always_comb begin
        dec_next  = StFetch;
        dec_legal = 1'b1;
        case (opcode)
            OpRtype:      dec_next = StExec;
            OpLw, OpSw:   dec_next = StMemAdr;
            OpBeq:        dec_next = StBranch;
            OpJ:          dec_next = StJump;
            OpAddi:       dec_next = StImmEx;
            OpAndi, OpOri: begin
                if (IMM_LOGIC_EN) begin
                    dec_next = StImmEx;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            default:      dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StFetch;
            op_q  <= 6'd0;
        end else begin
            case (state)
                StFetch:  if (mem_ready) state <= StDecode;
                StDecode: begin
                    op_q  <= opcode;
                    state <= dec_legal ? dec_next : StFetch;
                end
                StMemAdr: state <= (op_q == OpLw) ? StMemRd : StMemWr;
                StMemRd:  if (mem_ready) state <= StMemWb;
                StMemWb:  state <= StFetch;
                StMemWr:  if (mem_ready) state <= StFetch;
                StExec:   state <= StAluWb;
                StAluWb:  state <= StFetch;
                StBranch: state <= StFetch;
                StImmEx:  state <= StImmWb;
                StImmWb:  state <= StFetch;
                StJump:   state <= StFetch;
                default:  state <= StFetch;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'b00;
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        ext_sel    = 1'b1;
        illegal_op = 1'b0;

        case (state)
            StFetch: begin
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            StDecode: begin
                alu_src_b  = 2'b11;
                illegal_op = ~dec_legal;
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: i_or_d = 1'b1;
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            StMemWr: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
            end
            StAluWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            StImmEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StImmWb: reg_write = 1'b1;
            StJump: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase

        // ALU op and extender stay stable across IMMEX/IMMWB so the result is held.
        if (state == StImmEx || state == StImmWb) begin
            case (op_q)
                OpAndi: begin
                    alu_op  = 3'b011;
                    ext_sel = 1'b0;
                end
                OpOri: begin
                    alu_op  = 3'b100;
                    ext_sel = 1'b0;
                end
                default: begin
                    alu_op  = 3'b000;
                    ext_sel = 1'b1;
                end
            endcase
        end

        // Async reset must kill every write strobe in the same cycle it rises.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            branch    = 1'b0;
        end
    end

    assign state_o = state;

endmodule
